// File: rtl/alu_issue_queue.sv
// Command FIFO feeding the combinational ALU8bit datapath, with a registered
// result stage. Commands complete strictly in acceptance order.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_a,
    input  logic [7:0]        in_b,
    input  logic [3:0]        in_op,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op,
    input  logic [7:0]        alu_result,
    input  logic [15:0]       alu_product,
    input  logic              alu_of,
    input  logic              alu_zero,
    input  logic              alu_slt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_result,
    output logic [15:0]       out_product,
    output logic [3:0]        out_op,
    output logic              out_of,
    output logic              out_zero,
    output logic              out_slt,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        of_count
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    // Each entry packs {op, a, b}.
    logic [19:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [19:0]       head;
    logic              push;
    logic              issue;
    logic              not_empty;
    logic              head_is_addsub;

    assign not_empty = (count != '0);
    assign in_ready  = (count != FULL);
    assign push      = in_valid & in_ready;
    assign issue     = not_empty & (!out_valid | out_ready);
    assign head      = mem[rd_ptr];
    assign head_is_addsub = (head[19:16] == 4'd9) || (head[19:16] == 4'd10);

    // An empty queue presents a harmless idle opcode to the ALU.
    always_comb begin
        alu_a  = 8'd0;
        alu_b  = 8'd0;
        alu_op = 4'd15;
        if (not_empty) begin
            alu_op = head[19:16];
            alu_a  = head[15:8];
            alu_b  = head[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push && !issue) begin
                count <= count + (ADDR_W + 1)'(1);
            end else if (!push && issue) begin
                count <= count - (ADDR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_product <= '0;
            out_op      <= '0;
            out_of      <= 1'b0;
            out_zero    <= 1'b0;
            out_slt     <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_result  <= alu_result;
            out_product <= alu_product;
            out_op      <= head[19:16];
            out_of      <= alu_of;
            out_zero    <= alu_zero;
            out_slt     <= alu_slt;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Only signed ADD/SUB overflow is tallied; the counter sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_count <= '0;
        end else if (issue && alu_of && head_is_addsub && (of_count != 8'hFF)) begin
            of_count <= of_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue; a small behavioural ALU closes the loop
// between the queue's ALU drive and its capture inputs.
module tb_alu_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_result;
    logic [15:0] alu_product;
    logic        alu_of;
    logic        alu_zero;
    logic        alu_slt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic [15:0] out_product;
    logic [3:0]  out_op;
    logic        out_of;
    logic        out_zero;
    logic        out_slt;
    logic [2:0]  count;
    logic [7:0]  of_count;

    int checks = 0;
    int errors = 0;

    alu_issue_queue #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_product(alu_product),
        .alu_of(alu_of), .alu_zero(alu_zero), .alu_slt(alu_slt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_product(out_product), .out_op(out_op),
        .out_of(out_of), .out_zero(out_zero), .out_slt(out_slt),
        .count(count), .of_count(of_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcodes: 0 AND, 1 OR, 9 ADD, 10 SUB, 11 MUL, 15 idle; others return ~a.
    always_comb begin
        logic [7:0] t;
        t           = 8'd0;
        alu_result  = 8'd0;
        alu_product = 16'd0;
        alu_of      = 1'b0;
        case (alu_op)
            4'd0:  alu_result = alu_a & alu_b;
            4'd1:  alu_result = alu_a | alu_b;
            4'd9: begin
                t          = alu_a + alu_b;
                alu_result = t;
                alu_of     = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
            end
            4'd10: begin
                t          = alu_a - alu_b;
                alu_result = t;
                alu_of     = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
            end
            4'd11: begin
                alu_product = {8'd0, alu_a} * {8'd0, alu_b};
                alu_result  = alu_product[7:0];
            end
            4'd15: alu_result = 8'd0;
            default: alu_result = ~alu_a;
        endcase
        alu_zero = (alu_result == 8'd0);
        alu_slt  = ($signed(alu_a) < $signed(alu_b));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    logic [3:0]  s_op  [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
    logic [7:0]  s_a   [4] = '{8'hCC, 8'hCC, 8'h0F, 8'h03};
    logic [7:0]  s_b   [4] = '{8'hAA, 8'hAA, 8'h01, 8'h05};
    logic [7:0]  s_res [4] = '{8'h88, 8'hEE, 8'h0E, 8'h0F};
    logic [15:0] s_prd [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h000F};

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("reset_count", count, 0);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_alu_op_idle", alu_op, 15);
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_of_count", of_count, 0);
        check_output("reset_out_result", out_result, 0);

        $display("[TB] single ADD");
        out_ready = 1'b1;
        apply_stimulus(4'd9, 8'h0F, 8'h01);
        tick();
        in_valid = 1'b0;
        check_output("add_not_yet_valid", out_valid, 0);
        check_output("add_alu_op_head", alu_op, 9);
        check_output("add_alu_a_head", alu_a, 8'h0F);
        tick();
        check_output("add_valid", out_valid, 1);
        check_output("add_result", out_result, 8'h10);
        check_output("add_op", out_op, 9);
        check_output("add_zero", out_zero, 0);
        check_output("add_of", out_of, 0);
        check_output("add_count_empty", count, 0);
        tick();
        check_output("empty_valid_falls", out_valid, 0);
        check_output("empty_result_holds", out_result, 8'h10);

        $display("[TB] streaming");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(s_op[i], s_a[i], s_b[i]);
            tick();
            if (i > 0) begin
                check_output("stream_result", out_result, s_res[i-1]);
                check_output("stream_op", out_op, s_op[i-1]);
                check_output("stream_count", count, 1);
            end
        end
        in_valid = 1'b0;
        tick();
        check_output("stream_valid", out_valid, 1);
        check_output("stream_last_result", out_result, s_res[3]);
        check_output("stream_mul_product", out_product, s_prd[3]);
        tick();
        check_output("stream_drained", out_valid, 0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(4'd9, 8'(k), 8'h01);
            check_output("bp_in_ready_accept", in_ready, 1);
            tick();
        end
        apply_stimulus(4'd9, 8'd5, 8'h01);
        check_output("bp_in_ready_full", in_ready, 0);
        check_output("bp_count_full", count, 4);
        check_output("bp_first_result", out_result, 8'h01);
        tick();
        check_output("bp_hold_result", out_result, 8'h01);
        check_output("bp_hold_count", count, 4);
        out_ready = 1'b1;
        check_output("bp_full_during_pop", in_ready, 0);
        tick();
        check_output("bp_result_2", out_result, 8'h02);
        check_output("bp_ready_returns", in_ready, 1);
        check_output("bp_count_after_pop", count, 3);
        tick();
        in_valid = 1'b0;
        check_output("bp_result_3", out_result, 8'h03);
        check_output("bp_sixth_accepted", count, 3);
        for (int k = 4; k <= 6; k++) begin
            tick();
            check_output("bp_result_order", out_result, k);
        end
        check_output("bp_count_empty", count, 0);
        tick();
        check_output("bp_valid_falls", out_valid, 0);

        $display("[TB] flags and overflow counter");
        apply_stimulus(4'd9, 8'h80, 8'h80);
        tick();
        in_valid = 1'b0;
        tick();
        check_output("ovf_result", out_result, 8'h00);
        check_output("ovf_of", out_of, 1);
        check_output("ovf_zero", out_zero, 1);
        check_output("ovf_of_count", of_count, 1);
        apply_stimulus(4'd11, 8'h46, 8'h81);
        tick();
        in_valid = 1'b0;
        tick();
        check_output("mul_product", out_product, 16'h2346);
        check_output("mul_of_count_same", of_count, 1);
        apply_stimulus(4'd13, 8'h3C, 8'h00);
        tick();
        in_valid = 1'b0;
        tick();
        check_output("unfiltered_op", out_op, 13);
        check_output("unfiltered_result", out_result, 8'hC3);
        tick();
        check_output("flags_valid_falls", out_valid, 0);

        $display("[TB] simultaneous push and pop across wrap");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'd9, 8'(8'h20 + i), 8'h01);
            tick();
        end
        check_output("pp_count_two", count, 2);
        check_output("pp_result_held", out_result, 8'h21);
        out_ready = 1'b1;
        for (int i = 3; i < 5; i++) begin
            apply_stimulus(4'd9, 8'(8'h20 + i), 8'h01);
            tick();
            check_output("pp_count_stays", count, 2);
            check_output("pp_result_order", out_result, 8'(8'h1F + i));
        end
        in_valid = 1'b0;
        tick();
        check_output("pp_drain_a", out_result, 8'h24);
        tick();
        check_output("pp_drain_b", out_result, 8'h25);
        check_output("pp_drain_count", count, 0);
        tick();

        $display("[TB] reset mid operation");
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(4'd1, 8'(8'h40 + i), 8'h00);
            tick();
        end
        in_valid = 1'b0;
        check_output("mid_count_three", count, 3);
        check_output("mid_valid_before", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_reset_valid", out_valid, 0);
        check_output("mid_reset_count", count, 0);
        check_output("mid_reset_alu_op", alu_op, 15);
        check_output("mid_reset_of_count", of_count, 0);
        check_output("mid_reset_result", out_result, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        check_output("post_reset_in_ready", in_ready, 1);
        tick();
        tick();
        check_output("post_reset_no_result", out_valid, 0);
        check_output("post_reset_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
